// File: rtl/cdc_handshake_tx.sv
// Source end of a req/ack clock-domain crossing.
// Accepts one word on a valid/ready port, holds it on data_out and raises
// req_out toward the remote domain. The asynchronous ack_in is brought in
// through a SYNC_STAGES-deep flop chain before the FSM looks at it.
// Optional feature macro: CDC_HANDSHAKE_TX_TWO_PHASE_EN
//   undefined -> four-phase level protocol (IDLE/REQ_HI/ACK_LO)
//   defined   -> two-phase toggle protocol (IDLE/WAIT)
module cdc_handshake_tx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             tx_done
);

    // A single flop cannot resolve metastability, so shallow chains are refused.
    generate
        if (SYNC_STAGES < 2) begin : genBadSyncStages
            $error("cdc_handshake_tx: SYNC_STAGES must be at least 2");
        end
    endgenerate

`ifdef CDC_HANDSHAKE_TX_TWO_PHASE_EN
    typedef enum logic {
        IDLE,
        WAIT
    } StateT;
`else
    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        ACK_LO
    } StateT;
`endif

    StateT stateQ, stateD;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [WIDTH-1:0]       dataQ, dataD;
    logic                   reqQ, reqD;
    logic                   doneQ, doneD;
    logic                   ackS;

    // Shift the raw acknowledge through the synchronizer chain, bit 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ackS = syncQ[SYNC_STAGES-1];

    // Register the handshake state, request, held payload and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            reqQ   <= 1'b0;
            dataQ  <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            reqQ   <= reqD;
            dataQ  <= dataD;
            doneQ  <= doneD;
        end
    end

`ifdef CDC_HANDSHAKE_TX_TWO_PHASE_EN
    // Toggle protocol: each accept flips req, and the transfer closes once the
    // synchronized ack has caught up with the current req level.
    always_comb begin
        stateD   = stateQ;
        reqD     = reqQ;
        dataD    = dataQ;
        doneD    = 1'b0;
        in_ready = 1'b0;
        case (stateQ)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    stateD = WAIT;
                    reqD   = ~reqQ;
                    dataD  = in_data;
                end
            end
            WAIT: begin
                if (ackS == reqQ) begin
                    stateD = IDLE;
                    doneD  = 1'b1;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end
`else
    // Level protocol: raise req on accept, drop it when ack rises, and finish
    // once ack has returned low. A leftover high ack in IDLE blocks new accepts.
    always_comb begin
        stateD   = stateQ;
        reqD     = reqQ;
        dataD    = dataQ;
        doneD    = 1'b0;
        in_ready = 1'b0;
        case (stateQ)
            IDLE: begin
                in_ready = ~ackS;
                if (in_valid && !ackS) begin
                    stateD = REQ_HI;
                    reqD   = 1'b1;
                    dataD  = in_data;
                end
            end
            REQ_HI: begin
                if (ackS) begin
                    stateD = ACK_LO;
                    reqD   = 1'b0;
                end
            end
            ACK_LO: begin
                if (!ackS) begin
                    stateD = IDLE;
                    doneD  = 1'b1;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end
`endif

    assign data_out = dataQ;
    assign req_out  = reqQ;
    assign tx_done  = doneQ;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with SYNC_STAGES=2, WIDTH=32.
// Follows CDC_HANDSHAKE_TX_TWO_PHASE_EN so the same file covers both protocols.
module tb_cdc_handshake_tx;

    localparam int WIDTH = 32;
    localparam int SYNC  = 2;
`ifdef CDC_HANDSHAKE_TX_TWO_PHASE_EN
    localparam logic TWO = 1'b1;
    localparam int   P   = SYNC + 2;
`else
    localparam logic TWO = 1'b0;
    localparam int   P   = 2 * SYNC + 3;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] data_out;
    logic             req_out;
    logic             ack_in;
    logic             tx_done;

    logic             ackMode;
    logic             ackManual;
    logic             reqModel;
    int               vectors;
    int               miscompares;
    logic [31:0]      words [3];

    // The remote responder either echoes req instantly or is driven by hand.
    assign ack_in = ackMode ? req_out : ackManual;

    cdc_handshake_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .data_out (data_out),
        .req_out  (req_out),
        .ack_in   (ack_in),
        .tx_done  (tx_done)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Accept one word with the echo responder and check req and completion latency.
    task automatic runTransfer(input string tag, input logic [31:0] word);
        int  n;
        bit  found;
        applyStimulus(1'b1, word);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        reqModel = reqModel ^ TWO;
        checkOutput({tag, "_req"}, 32'(req_out), 32'(TWO ? reqModel : 1'b1));
        checkOutput({tag, "_data"}, data_out, word);
        n     = 1;
        found = (tx_done === 1'b1);
        while (!found && n < 20) begin
            nextCycle();
            n++;
            found = (tx_done === 1'b1);
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(P));
    endtask

    // Linear directed sequence: reset, single word, back-to-back, slow ack,
    // stale ack (level protocol only) and reset in the middle of a transfer.
    initial begin
        int   doneCount;
        int   idx;
        int   n;
        bit   found;
        logic [31:0] expData;

        words[0]    = 32'h0000_0001;
        words[1]    = 32'h0000_0002;
        words[2]    = 32'h0000_0003;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ackMode     = 1'b1;
        ackManual   = 1'b0;
        reqModel    = 1'b0;
        applyStimulus(1'b0, 32'h0);

        repeat (3) nextCycle();
        rst = 1'b0;
        checkOutput("rst_req", 32'(req_out), 32'd0);
        checkOutput("rst_data", data_out, 32'h0);
        checkOutput("rst_done", 32'(tx_done), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        nextCycle();
        checkOutput("rst_ready_hold", 32'(in_ready), 32'd1);
        checkOutput("rst_req_hold", 32'(req_out), 32'd0);

        applyStimulus(1'b1, 32'hDEADBEEF);
        checkOutput("sw_ready_pre", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        reqModel = reqModel ^ TWO;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) nextCycle();
            checkOutput("sw_data", data_out, 32'hDEADBEEF);
            checkOutput("sw_done", 32'(tx_done), 32'(k == P));
            checkOutput("sw_req", 32'(req_out), 32'(TWO ? reqModel : logic'(k <= 3)));
            checkOutput("sw_ready", 32'(in_ready), 32'(k >= P));
        end

        doneCount = 0;
        idx       = 0;
        for (int s = 0; s <= 3 * P + 2; s++) begin
            if (s > 0) begin
                nextCycle();
                if (((s - 1) % P) == 0 && idx < 3) begin
                    idx++;
                    reqModel = reqModel ^ TWO;
                end
            end
            if (idx < 3) applyStimulus(1'b1, words[idx]);
            else         applyStimulus(1'b0, 32'h0);
            if (s == 0)                 expData = 32'hDEADBEEF;
            else if ((s - 1) / P > 2)   expData = words[2];
            else                        expData = words[(s - 1) / P];
            checkOutput("b2b_data", data_out, expData);
            checkOutput("b2b_ready", 32'(in_ready), 32'((s % P) == 0 || s >= 3 * P));
            checkOutput("b2b_done", 32'(tx_done), 32'(s > 0 && (s % P) == 0 && s <= 3 * P));
            checkOutput("b2b_req", 32'(req_out),
                        32'(TWO ? reqModel : logic'(s >= 1 && s <= 3 * P && ((s - 1) % P) < 3)));
            if (tx_done === 1'b1) doneCount++;
        end
        checkOutput("b2b_done_total", 32'(doneCount), 32'd3);

        ackMode   = 1'b0;
        ackManual = 1'b0;
        applyStimulus(1'b1, 32'hA5A50001);
        nextCycle();
        reqModel = reqModel ^ TWO;
        for (int w = 1; w <= 50; w++) begin
            if (w > 1) nextCycle();
            applyStimulus(logic'(w >= 10 && w < 20), 32'hBAD0BAD0);
            checkOutput("slow_req", 32'(req_out), 32'(TWO ? reqModel : 1'b1));
            checkOutput("slow_ready", 32'(in_ready), 32'd0);
            checkOutput("slow_data", data_out, 32'hA5A50001);
            checkOutput("slow_done", 32'(tx_done), 32'd0);
        end
        applyStimulus(1'b0, 32'h0);
        ackManual = TWO ? reqModel : 1'b1;
`ifndef CDC_HANDSHAKE_TX_TWO_PHASE_EN
        n     = 0;
        found = 1'b0;
        while (!found && n < 10) begin
            nextCycle();
            n++;
            found = (req_out === 1'b0);
        end
        checkOutput("slow_reqfall_cycles", 32'(n), 32'd3);
        ackManual = 1'b0;
`endif
        n     = 0;
        found = 1'b0;
        while (!found && n < 10) begin
            nextCycle();
            n++;
            found = (tx_done === 1'b1);
        end
        checkOutput("slow_done_cycles", 32'(n), 32'd3);
        checkOutput("slow_data_after", data_out, 32'hA5A50001);
        checkOutput("slow_ready_after", 32'(in_ready), 32'd1);
        ackMode = 1'b1;

`ifndef CDC_HANDSHAKE_TX_TWO_PHASE_EN
        ackMode   = 1'b0;
        ackManual = 1'b1;
        rst       = 1'b1;
        applyStimulus(1'b0, 32'h0);
        repeat (3) nextCycle();
        rst = 1'b0;
        repeat (3) nextCycle();
        applyStimulus(1'b1, 32'h05717A1E);
        for (int k = 0; k < 4; k++) begin
            checkOutput("stale_ready", 32'(in_ready), 32'd0);
            checkOutput("stale_req", 32'(req_out), 32'd0);
            checkOutput("stale_data", data_out, 32'h0);
            nextCycle();
        end
        ackManual = 1'b0;
        nextCycle();
        checkOutput("stale_ready_d1", 32'(in_ready), 32'd0);
        nextCycle();
        checkOutput("stale_ready_d2", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("stale_req_d3", 32'(req_out), 32'd1);
        checkOutput("stale_data_d3", data_out, 32'h05717A1E);
        ackMode = 1'b1;
        n       = 0;
        found   = 1'b0;
        while (!found && n < 20) begin
            nextCycle();
            n++;
            found = (tx_done === 1'b1);
        end
        checkOutput("stale_done_seen", 32'(found), 32'd1);
        reqModel = 1'b0;
`else
        runTransfer("pre_mid", 32'h0F0F0F0F);
`endif

        applyStimulus(1'b1, 32'hC0FFEE00);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        reqModel = reqModel ^ TWO;
        checkOutput("mid_req_before", 32'(req_out), 32'(TWO ? reqModel : 1'b1));
        checkOutput("mid_data_before", data_out, 32'hC0FFEE00);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        reqModel = 1'b0;
        checkOutput("mid_req_after", 32'(req_out), 32'd0);
        checkOutput("mid_data_after", data_out, 32'h0);
        checkOutput("mid_done_after", 32'(tx_done), 32'd0);
        checkOutput("mid_ready_after", 32'(in_ready), 32'd1);
        runTransfer("post_mid", 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck handshake that no bounded loop would catch.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
